// File: rtl/ram_bus_controller.sv
// ram_bus_controller: single-request initiator for an 8-bit asynchronous SRAM
// bus. Sequences A/D/CS_BAR/WE_BAR through setup, strobe and hold phases with
// programmable strobe widths, and returns a one-cycle response pulse.
//
// Optional write-verify readback: define RAM_CTRL_WRVERIFY_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a request, bus parked (CS_BAR=1, WE_BAR=0)
// SETUP    | address/data/WE_BAR driven, CS_BAR still high
// STROBE   | CS_BAR low for RD_WAIT or WR_WAIT cycles (down-counter)
// END      | CS_BAR high, pins held for hold time, response (unless verify)
// V_SETUP  | verify: WE_BAR back to read, address held, CS_BAR high
// V_STROBE | verify: CS_BAR low for RD_WAIT cycles, readback captured
// V_END    | verify: CS_BAR high, response with rsp_err

module ram_bus_controller #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 3,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] O,
  output logic              CS_BAR,
  output logic              WE_BAR
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

`ifdef RAM_CTRL_WRVERIFY_EN
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, END, V_SETUP, V_STROBE, V_END
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, END
  } state_t;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
`ifdef RAM_CTRL_WRVERIFY_EN
  logic              err_q;
`endif

  assign A         = addr_q;
  assign D         = wdata_q;
  assign rsp_rdata = rdata_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request latch, strobe down-counter and read/verify data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
`ifdef RAM_CTRL_WRVERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
      end
      if (state == SETUP)
        cnt <= we_q ? CNT_W'(WR_WAIT - 1) : CNT_W'(RD_WAIT - 1);
      else if (state == STROBE && cnt != '0)
        cnt <= cnt - 1'b1;
`ifdef RAM_CTRL_WRVERIFY_EN
      else if (state == V_SETUP)
        cnt <= CNT_W'(RD_WAIT - 1);
      else if (state == V_STROBE && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == V_STROBE && cnt == '0)
        err_q <= (O != wdata_q);
`endif
      if (state == STROBE && cnt == '0 && !we_q)
        rdata_q <= O;
    end
  end

  // Next-state and bus pin decode
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    CS_BAR    = 1'b1;
    WE_BAR    = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SETUP;
      end
      SETUP: begin
        WE_BAR    = we_q;
        state_nxt = STROBE;
      end
      STROBE: begin
        CS_BAR = 1'b0;
        WE_BAR = we_q;
        if (cnt == '0) state_nxt = END;
      end
      END: begin
        WE_BAR = we_q;
`ifdef RAM_CTRL_WRVERIFY_EN
        if (we_q) begin
          state_nxt = V_SETUP;
        end else begin
          rsp_valid = 1'b1;
          state_nxt = IDLE;
        end
`else
        rsp_valid = 1'b1;
        state_nxt = IDLE;
`endif
      end
`ifdef RAM_CTRL_WRVERIFY_EN
      V_SETUP: begin
        state_nxt = V_STROBE;
      end
      V_STROBE: begin
        CS_BAR = 1'b0;
        if (cnt == '0) state_nxt = V_END;
      end
      V_END: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_bus_controller.sv
// Directed bench for ram_bus_controller with a behavioural async SRAM model.
module tb_ram_bus_controller;

  localparam int RD_WAIT = 3;
  localparam int WR_WAIT = 2;
`ifdef RAM_CTRL_WRVERIFY_EN
  localparam int WR_LAT  = WR_WAIT + RD_WAIT + 4;
  localparam int WR_CS   = WR_WAIT + RD_WAIT;
  localparam bit VERIFY  = 1'b1;
`else
  localparam int WR_LAT  = WR_WAIT + 2;
  localparam int WR_CS   = WR_WAIT;
  localparam bit VERIFY  = 1'b0;
`endif
  localparam int RD_LAT  = RD_WAIT + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] A, D, O;
  logic       CS_BAR, WE_BAR;

  logic [7:0] mem [256];
  logic       stuck = 1'b0;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  ram_bus_controller #(
    .ADDR_W(8), .DATA_W(8), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .A(A), .D(D), .O(O), .CS_BAR(CS_BAR), .WE_BAR(WE_BAR)
  );

  always #5 clk = ~clk;

  // SRAM model: write while strobed, read combinationally; optional stuck-at-0 bit 0
  always @(posedge clk) if (!CS_BAR && WE_BAR) mem[A] <= D;
  assign O = stuck ? (mem[A] & 8'hFE) : mem[A];

  // Bus protocol monitor: WE_BAR stable under CS_BAR low; no rsp_valid with req_ready
  logic prev_cs = 1'b1, prev_we = 1'b0;
  always @(negedge clk) begin
    if (!prev_cs && !CS_BAR && (WE_BAR !== prev_we)) viol++;
    if (rsp_valid && req_ready) viol++;
    prev_cs = CS_BAR;
    prev_we = WE_BAR;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One request from an IDLE negedge; returns at the following IDLE negedge.
  task automatic run_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        output logic [7:0] rd, output logic er);
    int lat = 0, cs_low = 0, we_bad = 0;
    int hold_lim = we ? WR_WAIT + 2 : RD_WAIT + 2;
    rd = 8'h00;
    er = 1'b0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("setup_a", A, addr);
        if (we) chk("setup_d", D, wdata);
        chk("setup_we", WE_BAR, we);
        chk("setup_cs", CS_BAR, 1'b1);
      end
      if (!CS_BAR) cs_low++;
      if (n <= hold_lim && WE_BAR !== we) we_bad++;
      if (rsp_valid) begin
        lat = n;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
    chk(we ? "wr_latency" : "rd_latency", lat, we ? WR_LAT : RD_LAT);
    chk("cs_low_cycles", cs_low, we ? WR_CS : RD_WAIT);
    chk("we_bar_held", we_bad, 0);
    @(negedge clk);
    chk("idle_after_op", req_ready, 1'b1);
  endtask

  logic [7:0] rd;
  logic       er;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_cs", CS_BAR, 1'b1);
    chk("rst_we", WE_BAR, 1'b0);
    chk("rst_a", A, 8'h00);
    chk("rst_d", D, 8'h00);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_err", rsp_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b1, 8'h10, 8'h3C, rd, er);
    chk("wr10_err", er, 1'b0);
    chk("mem10", mem[8'h10], 8'h3C);
    run_op(1'b0, 8'h10, 8'h00, rd, er);
    chk("rd10_data", rd, 8'h3C);
    chk("rd10_err", er, 1'b0);
    run_op(1'b1, 8'h20, 8'h55, rd, er);
    chk("rdata_held", rsp_rdata, 8'h3C);

    run_op(1'b1, 8'hFF, 8'hFF, rd, er);
    run_op(1'b1, 8'h00, 8'h00, rd, er);
    run_op(1'b0, 8'hFF, 8'h00, rd, er);
    chk("rdFF_data", rd, 8'hFF);
    run_op(1'b0, 8'h00, 8'h00, rd, er);
    chk("rd00_data", rd, 8'h00);
    run_op(1'b0, 8'h20, 8'h00, rd, er);
    chk("rd20_data", rd, 8'h55);

    // Back-to-back writes with req_valid held high
    begin
      int acc = 0;
      int cyc [3];
      req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'h77; req_valid = 1'b1;
      for (int n = 0; n < 60 && acc < 3; n++) begin
        if (req_ready) begin
          cyc[acc] = n;
          acc++;
        end
        if (acc == 3) begin
          @(posedge clk);
          #1 req_valid = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (req_ready) break;
      end
      chk("b2b_accepts", acc, 3);
      chk("b2b_space1", cyc[1] - cyc[0], WR_LAT + 1);
      chk("b2b_space2", cyc[2] - cyc[1], WR_LAT + 1);
      chk("b2b_idle", req_ready, 1'b1);
    end

    // Reset during the first STROBE cycle of a read
    begin
      int rsp_seen = 0;
      req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_strobe", CS_BAR, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cs", CS_BAR, 1'b1);
      chk("mid_rst_we", WE_BAR, 1'b0);
      chk("mid_rst_a", A, 8'h00);
      chk("mid_rst_ready", req_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (rsp_valid) rsp_seen++;
      end
      chk("no_rsp_after_rst", rsp_seen, 0);
      chk("rdata_after_rst", rsp_rdata, 8'h00);
      run_op(1'b0, 8'h10, 8'h00, rd, er);
      chk("rd_after_rst", rd, 8'h3C);
    end

    // Stuck-at-0 on bit 0 of the RAM data output
    stuck = 1'b1;
    run_op(1'b1, 8'h30, 8'h01, rd, er);
    chk("verify_err_01", er, VERIFY);
    run_op(1'b1, 8'h31, 8'h02, rd, er);
    chk("verify_err_02", er, 1'b0);
    chk("verify_rdata_kept", rsp_rdata, 8'h3C);
    stuck = 1'b0;

    chk("protocol_viol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d exp %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
